fb_port_arbiter: RTL

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_wr_fifo.sv | 62 ++++++
 rtl/fb_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer geometry and arbitration types shared by the display/host
// memory path.
package fb_pkg;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 16;
   localparam int FB_H   = 480;
   localparam int FB_V   = 320;
   localparam int unsigned FB_SIZE = FB_H * FB_V;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_READ,
      SLOT_WRITE
   } slot_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// Host write queue: strict FIFO with occupancy count. The caller never pushes
// when o_full is set and never pops when o_empty is set.
module fb_wr_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;

   // NOTE: storage is not reset; the pointers and level alone say which entries are live.
   always_ff @(posedge i_clk) begin
      if (i_push) mem_q[wr_ptr_q] <= i_data;
   end

   // NOTE: every always_comb output gets a default first so no latch can be inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (i_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({i_push, i_pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_full  = (level_q == LVL_W'(DEPTH));
   assign o_empty = (level_q == '0);
   assign o_level = level_q;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer RAM arbiter: display reads always win the slot,
// host writes are queued and drained in idle cycles.
module fb_port_arbiter #(
   parameter int ADDR_W       = fb_pkg::ADDR_W,
   parameter int DATA_W       = fb_pkg::DATA_W,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 1024
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_rd_en,
   input  logic [ADDR_W-1:0]             i_rd_addr,
   output logic [DATA_W-1:0]             o_rd_data,
   output logic                          o_rd_valid,
   input  logic                          i_wr_valid,
   output logic                          o_wr_ready,
   input  logic [ADDR_W-1:0]             i_wr_addr,
   input  logic [DATA_W-1:0]             i_wr_data,
   output logic                          o_mem_en,
   output logic                          o_mem_we,
   output logic [ADDR_W-1:0]             o_mem_addr,
   output logic [DATA_W-1:0]             o_mem_wdata,
   input  logic [DATA_W-1:0]             i_mem_rdata,
   input  logic                          i_clr_status,
   output logic                          o_wr_drop,
   output logic                          o_wr_starve,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int ENT_W = ADDR_W + DATA_W;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

   fb_pkg::slot_e     slot;
   logic              fifo_full, fifo_empty;
   logic [ENT_W-1:0]  fifo_head;
   logic              wr_fire, wr_in_range, push, pop, drop_set, starve_set;

   logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        rd_pipe_q, rd_pipe_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
   logic              drop_q, drop_d, starve_q, starve_d;

   // Out-of-range writes are handshaken like any other but never queued.
   assign wr_fire     = i_wr_valid & o_wr_ready;
   assign wr_in_range = (32'(i_wr_addr) < fb_pkg::FB_SIZE);
   assign push        = wr_fire & wr_in_range;
   assign drop_set    = wr_fire & ~wr_in_range;
   assign pop         = (slot == fb_pkg::SLOT_WRITE);

   always_comb begin
      slot = fb_pkg::SLOT_IDLE;
      if (i_rd_en)          slot = fb_pkg::SLOT_READ;
      else if (!fifo_empty) slot = fb_pkg::SLOT_WRITE;
   end

   fb_wr_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  ({i_wr_addr, i_wr_data}),
      .i_pop   (pop),
      .o_data  (fifo_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (o_fifo_level)
   );

   always_comb begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (slot)
         fb_pkg::SLOT_READ: begin
            mem_en_d   = 1'b1;
            mem_addr_d = i_rd_addr;
         end
         fb_pkg::SLOT_WRITE: begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = fifo_head[ENT_W-1:DATA_W];
            mem_wdata_d = fifo_head[DATA_W-1:0];
         end
         default: ;
      endcase
   end

   // Two-stage read pipe: address register, then the RAM's own read register.
   assign rd_pipe_d = {rd_pipe_q[0], i_rd_en};
   assign rd_data_d = rd_pipe_q[1] ? i_mem_rdata : rd_data_q;

   always_comb begin
      starve_cnt_d = '0;
      if (fifo_full) starve_cnt_d = (starve_cnt_q == LIMIT_C) ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
   end

   assign starve_set = (starve_cnt_d == LIMIT_C);
   assign drop_d     = drop_set   | (drop_q   & ~i_clr_status);
   assign starve_d   = starve_set | (starve_q & ~i_clr_status);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         rd_pipe_q    <= '0;
         rd_data_q    <= '0;
         starve_cnt_q <= '0;
         drop_q       <= 1'b0;
         starve_q     <= 1'b0;
      end else begin
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         rd_pipe_q    <= rd_pipe_d;
         rd_data_q    <= rd_data_d;
         starve_cnt_q <= starve_cnt_d;
         drop_q       <= drop_d;
         starve_q     <= starve_d;
      end
   end

   assign o_wr_ready  = ~fifo_full;
   assign o_mem_en    = mem_en_q;
   assign o_mem_we    = mem_we_q;
   assign o_mem_addr  = mem_addr_q;
   assign o_mem_wdata = mem_wdata_q;
   assign o_rd_valid  = rd_pipe_q[1];
   assign o_rd_data   = rd_pipe_q[1] ? i_mem_rdata : rd_data_q;
   assign o_wr_drop   = drop_q;
   assign o_wr_starve = starve_q;

endmodule
